// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int REG_W           = 5;
  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-field inputs and pipeline-control outputs of pipe_ctrl.
// The slave modport is the controller; the master modport drives the pipeline fields.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             ex_MemRead;
   logic [REG_W-1:0] ex_rfile_wn;
   logic             mem_Branch;
   logic             mem_Beq;
   logic             mem_zero;
   logic             mem_bgtz;
   logic             mem_MemRead;
   logic             mem_MemWrite;
   logic             mem_ready;

   logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
   logic flush_ifid, flush_idex, flush_exmem, flush_memwb;
   logic pc_sel;
   logic mem_err;

   modport slave (
      input  id_rs, id_rt, ex_MemRead, ex_rfile_wn,
      input  mem_Branch, mem_Beq, mem_zero, mem_bgtz,
      input  mem_MemRead, mem_MemWrite, mem_ready,
      output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
      output flush_ifid, flush_idex, flush_exmem, flush_memwb,
      output pc_sel, mem_err
   );

   modport master (
      output id_rs, id_rt, ex_MemRead, ex_rfile_wn,
      output mem_Branch, mem_Beq, mem_zero, mem_bgtz,
      output mem_MemRead, mem_MemWrite, mem_ready,
      input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
      input  flush_ifid, flush_idex, flush_exmem, flush_memwb,
      input  pc_sel, mem_err
   );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: the load in EX writes a register the ID instruction reads.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_MemRead,
   input  logic [REG_W-1:0] ex_rfile_wn,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             lu
);

   // Register 0 is hard-wired to zero, so a load into it never creates a dependency.
   assign lu = ex_MemRead && (ex_rfile_wn != '0) &&
               ((ex_rfile_wn == id_rs) || (ex_rfile_wn == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: memory-wait FSM with timeout, branch flush and load-use stall.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_inc;
   logic             err_q;
   logic             lu;
   logic             br_tk;
   logic             ms;
   logic             timeout_hit;

   hazard_detect u_hazard (
      .ex_MemRead  (bus.ex_MemRead),
      .ex_rfile_wn (bus.ex_rfile_wn),
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .lu          (lu)
   );

   assign br_tk = (bus.mem_Branch && (bus.mem_Beq ? bus.mem_zero : !bus.mem_zero))
                  || bus.mem_bgtz;
   assign ms    = (bus.mem_MemRead || bus.mem_MemWrite) && !bus.mem_ready;

   assign wait_inc = (wait_cnt == CNT_W'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1;

   // wait_cnt holds the stall cycles already completed, so the current stall
   // cycle is the MEM_TIMEOUT-th one when wait_cnt equals MEM_TIMEOUT-1.
   assign timeout_hit = ms && (wait_cnt >= CNT_W'(MEM_TIMEOUT - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (ms) begin
                  state    <= MEMWAIT;
                  wait_cnt <= wait_inc;
               end else begin
                  wait_cnt <= '0;
               end
            end
            MEMWAIT: begin
               if (ms) begin
                  wait_cnt <= wait_inc;
               end else begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
         if (timeout_hit) err_q <= 1'b1;
      end
   end

   // NOTE: every output gets a default before the priority chain so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      bus.en_pc       = 1'b1;
      bus.en_ifid     = 1'b1;
      bus.en_idex     = 1'b1;
      bus.en_exmem    = 1'b1;
      bus.en_memwb    = 1'b1;
      bus.flush_ifid  = 1'b0;
      bus.flush_idex  = 1'b0;
      bus.flush_exmem = 1'b0;
      bus.flush_memwb = 1'b0;
      bus.pc_sel      = 1'b0;
      if (rst) begin
         bus.en_pc       = 1'b0;
         bus.en_ifid     = 1'b0;
         bus.en_idex     = 1'b0;
         bus.en_exmem    = 1'b0;
         bus.en_memwb    = 1'b0;
         bus.flush_ifid  = 1'b1;
         bus.flush_idex  = 1'b1;
         bus.flush_exmem = 1'b1;
         bus.flush_memwb = 1'b1;
      end else if (ms) begin
         bus.en_pc       = 1'b0;
         bus.en_ifid     = 1'b0;
         bus.en_idex     = 1'b0;
         bus.en_exmem    = 1'b0;
         bus.flush_memwb = 1'b1;
      end else if (br_tk) begin
         // The squashed ID instruction makes any concurrent load-use stall moot.
         bus.pc_sel      = 1'b1;
         bus.flush_ifid  = 1'b1;
         bus.flush_idex  = 1'b1;
         bus.flush_exmem = 1'b1;
      end else if (lu) begin
         bus.en_pc       = 1'b0;
         bus.en_ifid     = 1'b0;
         bus.flush_idex  = 1'b1;
      end
   end

   assign bus.mem_err = !rst && (err_q || timeout_hit);

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (ms || lu) stall_cnt <= stall_cnt + 32'd1;
         if (br_tk)    flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a cycle-level reference model.
// Builds with or without PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

   localparam int T = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
   pipe_ctrl #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus),
                                     .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
   pipe_ctrl #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct packed {
      logic       rst;
      logic [4:0] rs, rt;
      logic       ex_mr;
      logic [4:0] wn;
      logic       br, beq, zero, bgtz;
      logic       mrd, mwr, rdy;
   } stim_t;

   stim_t s;
   int checks = 0;
   int errors = 0;

   // Reference state: length of the current run of consecutive memory-stall cycles.
   int          run_len;
   bit          err_sticky;
   logic [31:0] m_stall, m_flush;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output vector order: en_pc en_ifid en_idex en_exmem en_memwb
   //                      flush_ifid flush_idex flush_exmem flush_memwb pc_sel mem_err
   function automatic logic [10:0] dut_vec();
      return {bus.en_pc, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb,
              bus.flush_ifid, bus.flush_idex, bus.flush_exmem, bus.flush_memwb,
              bus.pc_sel, bus.mem_err};
   endfunction

   task automatic step(input string tag);
      bit ms, br, lu, err_now;
      logic [10:0] exp;
      rst              = s.rst;
      bus.id_rs        = s.rs;
      bus.id_rt        = s.rt;
      bus.ex_MemRead   = s.ex_mr;
      bus.ex_rfile_wn  = s.wn;
      bus.mem_Branch   = s.br;
      bus.mem_Beq      = s.beq;
      bus.mem_zero     = s.zero;
      bus.mem_bgtz     = s.bgtz;
      bus.mem_MemRead  = s.mrd;
      bus.mem_MemWrite = s.mwr;
      bus.mem_ready    = s.rdy;
      #1;
      ms = (s.mrd || s.mwr) && !s.rdy;
      br = (s.br && (s.beq ? s.zero : !s.zero)) || s.bgtz;
      lu = s.ex_mr && (s.wn != 0) && (s.wn == s.rs || s.wn == s.rt);
      err_now = !s.rst && (err_sticky || (ms && run_len + 1 >= T));
      if (s.rst)    exp = 11'b00000_1111_0_0;
      else if (ms)  exp = {10'b00001_0001_0, err_now};
      else if (br)  exp = {10'b11111_1110_1, err_now};
      else if (lu)  exp = {10'b00111_0100_0, err_now};
      else          exp = {10'b11111_0000_0, err_now};
      check(tag, 32'(dut_vec()), 32'(exp));
`ifdef PIPE_CTRL_PERF_EN
      check({tag, "_stallcnt"}, stall_cnt, m_stall);
      check({tag, "_flushcnt"}, flush_cnt, m_flush);
`endif
      if (s.rst) begin
         run_len = 0; err_sticky = 0; m_stall = 0; m_flush = 0;
      end else begin
         run_len    = ms ? run_len + 1 : 0;
         err_sticky = err_sticky | err_now;
         if (ms || lu) m_stall = m_stall + 1;
         if (br)       m_flush = m_flush + 1;
      end
      @(negedge clk);
   endtask

   initial begin
      run_len = 0; err_sticky = 0; m_stall = 0; m_flush = 0;
      s = '0;

      // Reset state
      s.rst = 1; step("reset0"); step("reset1");
      s.rst = 0; step("idle");

      // Load-use
      s.ex_mr = 1; s.wn = 8; s.rs = 8; step("lu_rs8");
      s = '0; step("lu_done");
      s.ex_mr = 1; s.wn = 0; s.rs = 0; step("lu_r0_none");
      s.wn = 9; s.rs = 3; s.rt = 9; step("lu_rt9");
      s = '0;

      // Branches
      s.br = 1; s.beq = 1; s.zero = 1; step("beq_taken");
      s.zero = 0; step("beq_not_taken");
      s.beq = 0; s.zero = 0; step("bne_taken");
      s = '0; s.bgtz = 1; step("bgtz_taken");
      s = '0; step("br_done");

      // Memory wait: 3 stall cycles, then ready
      s.mrd = 1; s.rdy = 0;
      step("mw1"); step("mw2"); step("mw3");
      s.rdy = 1; step("mw_ready");
      s = '0; step("mw_idle");

      // Timeout: store held without ready for 6 cycles
      s.mwr = 1; s.rdy = 0;
      for (int i = 1; i <= 6; i++) step($sformatf("to%0d", i));
      s.rdy = 1; step("to_ready");
      s = '0; step("to_sticky");

      // lu together with br_tk
      s.ex_mr = 1; s.wn = 5; s.rs = 5; s.br = 1; s.beq = 1; s.zero = 1;
      step("lu_br");
      // ms together with br_tk: freeze, then branch in the ready cycle
      s.mrd = 1; s.rdy = 0; s.ex_mr = 0;
      step("ms_br1"); step("ms_br2");
      s.rdy = 1; step("ms_br_ready");
      s = '0; step("ms_br_done");

      // Reset mid-wait clears error and counter
      s.mrd = 1; s.rdy = 0; step("rw1"); step("rw2");
      s.rst = 1; step("rw_rst");
      s = '0; step("rw_release");
      s.mrd = 1; step("rw_s1"); step("rw_s2"); step("rw_s3");
      s.rdy = 1; step("rw_ready");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         s.rst   = ($urandom_range(0, 59) == 0);
         s.rs    = 5'($urandom_range(0, 3));
         s.rt    = 5'($urandom_range(0, 3));
         s.ex_mr = 1'($urandom_range(0, 1));
         s.wn    = 5'($urandom_range(0, 3));
         s.br    = ($urandom_range(0, 3) == 0);
         s.beq   = 1'($urandom_range(0, 1));
         s.zero  = 1'($urandom_range(0, 1));
         s.bgtz  = ($urandom_range(0, 7) == 0);
         s.mrd   = ($urandom_range(0, 2) == 0);
         s.mwr   = ($urandom_range(0, 4) == 0);
         s.rdy   = ($urandom_range(0, 3) != 0);
         step($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
